// File: rtl/ps2_cmd_interp.sv
// ps2_cmd_interp
// ----------------------------------------------------------------------------
// Turns PS/2 keyboard scan codes into setpoint and alarm commands for the
// temperature controller. Digits typed after Enter build an NDIG-digit BCD
// value that is committed into one of NFIELD setpoint fields. The fields are
// filled round-robin. The letter keys H/A/G raise sticky alarm flags, and R
// clears the flags and emits a global reset pulse. Key-release (F0) and
// extended (E0) prefixes are filtered. An entry left idle for TIMEOUT cycles
// is abandoned.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESETn     in   synchronous active-low reset
//   flag       in   byte-ready level from the PS/2 receiver; its rising edge
//                   marks a new byte
//   DATO       in   8-bit scan code, valid while flag is high
//   STtemp     out  packed BCD fields; field k is [k*4*NDIG +: 4*NDIG]
//   STPeligro  out  sticky danger flag (H)
//   STAlerta   out  sticky alert flag (A)
//   STGas      out  sticky gas flag (G)
//   Greset     out  one-cycle global reset pulse (R)
//   CMD_VALID  out  one-cycle pulse when a field is committed
//   ERR        out  one-cycle pulse on an empty Enter or an entry timeout
//   FIELD_SEL  out  index of the next field to be written
//   BUSY       out  high while an entry is open
// ----------------------------------------------------------------------------
module ps2_cmd_interp #(
  parameter int NDIG    = 2,
  parameter int NFIELD  = 2,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic                                         CLK,
  input  logic                                         RESETn,
  input  logic                                         flag,
  input  logic [7:0]                                   DATO,
  output logic [NFIELD*NDIG*4-1:0]                     STtemp,
  output logic                                         STPeligro,
  output logic                                         STAlerta,
  output logic                                         STGas,
  output logic                                         Greset,
  output logic                                         CMD_VALID,
  output logic                                         ERR,
  output logic [((NFIELD > 1) ? $clog2(NFIELD) : 1)-1:0] FIELD_SEL,
  output logic                                         BUSY
);

  localparam int BW  = 4 * NDIG;
  localparam int FSW = (NFIELD > 1) ? $clog2(NFIELD) : 1;
  localparam int CW  = $clog2(NDIG + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE,
    S_ENTRY
  } state_t;

  typedef enum logic [3:0] {
    K_NONE,
    K_DIGIT,
    K_ENTER,
    K_H,
    K_A,
    K_G,
    K_R,
    K_BS,
    K_ESC
  } key_t;

  state_t                  r_state;
  logic                    r_flag_q;
  logic                    r_brk_pend;
  logic                    r_ext_pend;
  logic [TW-1:0]           r_tcnt;
  logic [BW-1:0]           r_buf;
  logic [CW-1:0]           r_cnt;
  logic [NFIELD*BW-1:0]    r_temp;
  logic                    r_peligro;
  logic                    r_alerta;
  logic                    r_gas;
  logic                    r_greset;
  logic                    r_cmd_valid;
  logic                    r_err;
  logic [FSW-1:0]          r_field_sel;
  logic                    r_busy;

  logic                    w_accept;
  key_t                    w_key;
  logic [3:0]              w_digit;
  logic                    w_commit;

  // A byte is taken only on the low-to-high transition of flag. r_flag_q
  // resets high, so a flag still high after reset is never mistaken for a
  // new byte.
  assign w_accept = flag & ~r_flag_q;

  // Scan-code decoder: classifies the byte and extracts the BCD digit value.
  always_comb begin
    w_key   = K_NONE;
    w_digit = 4'd0;
    case (DATO)
      8'h45: begin w_key = K_DIGIT; w_digit = 4'd0; end
      8'h16: begin w_key = K_DIGIT; w_digit = 4'd1; end
      8'h1E: begin w_key = K_DIGIT; w_digit = 4'd2; end
      8'h26: begin w_key = K_DIGIT; w_digit = 4'd3; end
      8'h25: begin w_key = K_DIGIT; w_digit = 4'd4; end
      8'h2E: begin w_key = K_DIGIT; w_digit = 4'd5; end
      8'h36: begin w_key = K_DIGIT; w_digit = 4'd6; end
      8'h3D: begin w_key = K_DIGIT; w_digit = 4'd7; end
      8'h3E: begin w_key = K_DIGIT; w_digit = 4'd8; end
      8'h46: begin w_key = K_DIGIT; w_digit = 4'd9; end
      8'h5A: w_key = K_ENTER;
      8'h33: w_key = K_H;
      8'h1C: w_key = K_A;
      8'h34: w_key = K_G;
      8'h2D: w_key = K_R;
      8'h66: w_key = K_BS;
      8'h76: w_key = K_ESC;
      default: w_key = K_NONE;
    endcase
  end

  // Enter and H/A/G close a non-empty entry with a commit. The caller only
  // consults this for a decoded (non-prefix, non-discarded) byte.
  assign w_commit = (r_state == S_ENTRY) && (r_cnt != '0) &&
                    ((w_key == K_ENTER) || (w_key == K_H) ||
                     (w_key == K_A) || (w_key == K_G));

  // Interpreter FSM. Every effect of a byte lands on its accept edge. The
  // timeout counter only advances on edges where no byte is taken, so an
  // arriving byte always beats a timeout that would fire on the same edge.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_flag_q    <= 1'b1;
      r_brk_pend  <= 1'b0;
      r_ext_pend  <= 1'b0;
      r_tcnt      <= '0;
      r_buf       <= '0;
      r_cnt       <= '0;
      r_temp      <= '0;
      r_peligro   <= 1'b0;
      r_alerta    <= 1'b0;
      r_gas       <= 1'b0;
      r_greset    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      r_field_sel <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_flag_q    <= flag;
      r_greset    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;

      if (w_accept) begin
        r_tcnt <= '0;
        if (r_brk_pend) begin
          // Key-release code: swallow the byte and change nothing else.
          r_brk_pend <= 1'b0;
        end else if (DATO == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (DATO == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          if (r_ext_pend) begin
            r_ext_pend <= 1'b0;
          end

          // Letter keys act the same way in both states.
          case (w_key)
            K_H: r_peligro <= 1'b1;
            K_A: r_alerta  <= 1'b1;
            K_G: r_gas     <= 1'b1;
            K_R: begin
              r_peligro <= 1'b0;
              r_alerta  <= 1'b0;
              r_gas     <= 1'b0;
              r_greset  <= 1'b1;
            end
            default: ;
          endcase

          if (r_state == S_IDLE) begin
            if (w_key == K_ENTER) begin
              r_state <= S_ENTRY;
              r_busy  <= 1'b1;
              r_buf   <= '0;
              r_cnt   <= '0;
            end
          end else begin
            case (w_key)
              K_DIGIT: begin
                // Shift in at the LSB; older digits fall off the top.
                r_buf <= (r_buf << 4) | BW'(w_digit);
                if (r_cnt != CW'(NDIG)) begin
                  r_cnt <= r_cnt + CW'(1);
                end
              end
              K_BS: begin
                r_buf <= '0;
                r_cnt <= '0;
              end
              K_ENTER: begin
                if (r_cnt == '0) begin
                  r_err <= 1'b1;
                end
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
              K_H, K_A, K_G, K_R, K_ESC: begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
              default: ;
            endcase
          end

          if (w_commit) begin
            r_temp[int'(r_field_sel) * BW +: BW] <= r_buf;
            r_cmd_valid <= 1'b1;
            if (r_field_sel == FSW'(NFIELD - 1)) begin
              r_field_sel <= '0;
            end else begin
              r_field_sel <= r_field_sel + FSW'(1);
            end
          end
        end
      end else if (r_state == S_ENTRY) begin
        if (r_tcnt == TW'(TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_buf   <= '0;
          r_cnt   <= '0;
          r_tcnt  <= '0;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

  assign STtemp    = r_temp;
  assign STPeligro = r_peligro;
  assign STAlerta  = r_alerta;
  assign STGas     = r_gas;
  assign Greset    = r_greset;
  assign CMD_VALID = r_cmd_valid;
  assign ERR       = r_err;
  assign FIELD_SEL = r_field_sel;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_ps2_cmd_interp.sv
// tb_ps2_cmd_interp
// ----------------------------------------------------------------------------
// Directed bench for ps2_cmd_interp with NDIG=2, NFIELD=2 and a short
// TIMEOUT of 20 cycles, so the entry timeout can be reached quickly. Bytes
// are sent as flag pulses. Expected values are written out by hand.
// ----------------------------------------------------------------------------
module tb_ps2_cmd_interp;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        flag;
  logic [7:0]  DATO;
  logic [15:0] STtemp;
  logic        STPeligro;
  logic        STAlerta;
  logic        STGas;
  logic        Greset;
  logic        CMD_VALID;
  logic        ERR;
  logic [0:0]  FIELD_SEL;
  logic        BUSY;

  int checkCount = 0;
  int errorCount = 0;
  int cmdPulses  = 0;
  int errPulses  = 0;
  int grsPulses  = 0;
  int c0;
  int e0;
  int g0;

  logic       sCmd, sErr, sGrs;
  logic       sCmdAfter, sErrAfter, sGrsAfter;
  logic [2:0] sFlags;

  ps2_cmd_interp #(
    .NDIG    (2),
    .NFIELD  (2),
    .TIMEOUT (20)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .flag      (flag),
    .DATO      (DATO),
    .STtemp    (STtemp),
    .STPeligro (STPeligro),
    .STAlerta  (STAlerta),
    .STGas     (STGas),
    .Greset    (Greset),
    .CMD_VALID (CMD_VALID),
    .ERR       (ERR),
    .FIELD_SEL (FIELD_SEL),
    .BUSY      (BUSY)
  );

  // 100 MHz clock.
  always #5 CLK = ~CLK;

  // Pulse counters, sampled shortly after each rising edge so that a
  // one-cycle pulse is counted exactly once.
  always @(posedge CLK) begin
    #2;
    if (CMD_VALID) cmdPulses++;
    if (ERR)       errPulses++;
    if (Greset)    grsPulses++;
  end

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one scan code as a single flag pulse (one cycle high, one cycle
  // low). It is entered and left on a falling edge. It records the pulse
  // outputs right after the accept edge and one cycle later.
  task automatic applyStimulus(input logic [7:0] code);
    DATO = code;
    flag = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    sCmd   = CMD_VALID;
    sErr   = ERR;
    sGrs   = Greset;
    sFlags = {STPeligro, STAlerta, STGas};
    flag = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    sCmdAfter = CMD_VALID;
    sErrAfter = ERR;
    sGrsAfter = Greset;
  endtask

  task automatic resetDut();
    RESETn = 1'b0;
    flag   = 1'b0;
    DATO   = 8'h00;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    RESETn = 1'b0;
    flag   = 1'b0;
    DATO   = 8'h00;
    @(negedge CLK);
    resetDut();

    $display("[TB] reset state");
    checkOutput("rst_sttemp", 32'(STtemp), 'h0);
    checkOutput("rst_fieldsel", 32'(FIELD_SEL), 0);
    checkOutput("rst_busy", 32'(BUSY), 0);
    checkOutput("rst_flags", 32'({STPeligro, STAlerta, STGas}), 0);

    $display("[TB] enter 1 8 H");
    applyStimulus(8'h5A);
    checkOutput("t1_busy_entry", 32'(BUSY), 1);
    applyStimulus(8'h16);
    applyStimulus(8'h3E);
    c0 = cmdPulses;
    applyStimulus(8'h33);
    checkOutput("t1_cmd_pulse", 32'(sCmd), 1);
    checkOutput("t1_peligro_same_edge", 32'(sFlags), 'b100);
    checkOutput("t1_cmd_one_cycle", 32'(sCmdAfter), 0);
    checkOutput("t1_field0", 32'(STtemp), 'h0018);
    checkOutput("t1_fieldsel", 32'(FIELD_SEL), 1);
    checkOutput("t1_busy_idle", 32'(BUSY), 0);
    checkOutput("t1_cmd_count", 32'(cmdPulses - c0), 1);

    $display("[TB] prefix filtering");
    resetDut();
    applyStimulus(8'h1C);
    checkOutput("t2_alerta", 32'(sFlags), 'b010);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    applyStimulus(8'h33);
    checkOutput("t2_break_discard", 32'({STPeligro, STAlerta, STGas}), 'b010);
    applyStimulus(8'hE0);
    applyStimulus(8'h34);
    checkOutput("t2_ext_gas", 32'({STPeligro, STAlerta, STGas}), 'b011);

    $display("[TB] digit entry and field rotation");
    resetDut();
    applyStimulus(8'h5A);
    applyStimulus(8'h16);
    applyStimulus(8'h1E);
    applyStimulus(8'h26);
    applyStimulus(8'h5A);
    checkOutput("t3_field0_23", 32'(STtemp), 'h0023);
    checkOutput("t3_sel_1", 32'(FIELD_SEL), 1);
    applyStimulus(8'h5A);
    applyStimulus(8'h3D);
    applyStimulus(8'h5A);
    checkOutput("t3_field1_07", 32'(STtemp), 'h0723);
    checkOutput("t3_sel_wrap", 32'(FIELD_SEL), 0);
    applyStimulus(8'h5A);
    applyStimulus(8'h25);
    applyStimulus(8'h66);
    checkOutput("t3_busy_after_bs", 32'(BUSY), 1);
    applyStimulus(8'h46);
    applyStimulus(8'h5A);
    checkOutput("t3_field0_09", 32'(STtemp), 'h0709);
    checkOutput("t3_sel_again", 32'(FIELD_SEL), 1);

    $display("[TB] empty enter and escape");
    c0 = cmdPulses;
    applyStimulus(8'h5A);
    applyStimulus(8'h5A);
    checkOutput("t4_err_pulse", 32'(sErr), 1);
    checkOutput("t4_no_cmd", 32'(sCmd), 0);
    checkOutput("t4_err_one_cycle", 32'(sErrAfter), 0);
    checkOutput("t4_busy", 32'(BUSY), 0);
    applyStimulus(8'h5A);
    applyStimulus(8'h2E);
    applyStimulus(8'h76);
    checkOutput("t4_esc_busy", 32'(BUSY), 0);
    checkOutput("t4_esc_fields", 32'(STtemp), 'h0709);
    checkOutput("t4_esc_no_commit", 32'(cmdPulses - c0), 0);
    checkOutput("t4_esc_sel", 32'(FIELD_SEL), 1);

    $display("[TB] entry timeout");
    applyStimulus(8'h5A);
    applyStimulus(8'h2E);
    // One idle edge has already gone by inside applyStimulus.
    repeat (18) @(posedge CLK);
    @(negedge CLK);
    checkOutput("t5_no_err_19", 32'(ERR), 0);
    checkOutput("t5_busy_19", 32'(BUSY), 1);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t5_err_20", 32'(ERR), 1);
    checkOutput("t5_busy_20", 32'(BUSY), 0);
    @(negedge CLK);
    checkOutput("t5_err_one_cycle", 32'(ERR), 0);
    checkOutput("t5_fields", 32'(STtemp), 'h0709);

    // A byte arriving mid-entry restarts the idle count.
    e0 = errPulses;
    applyStimulus(8'h5A);
    repeat (14) @(posedge CLK);
    @(negedge CLK);
    applyStimulus(8'h16);
    repeat (16) @(posedge CLK);
    @(negedge CLK);
    checkOutput("t5_restart_busy", 32'(BUSY), 1);
    checkOutput("t5_restart_no_err", 32'(errPulses - e0), 0);
    applyStimulus(8'h76);

    $display("[TB] letters, R and reset with flag held");
    resetDut();
    applyStimulus(8'h5A);
    applyStimulus(8'h25);
    applyStimulus(8'h1E);
    applyStimulus(8'h33);
    applyStimulus(8'h1C);
    applyStimulus(8'h34);
    checkOutput("t6_all_flags", 32'({STPeligro, STAlerta, STGas}), 'b111);
    checkOutput("t6_field0_42", 32'(STtemp), 'h0042);
    g0 = grsPulses;
    applyStimulus(8'h2D);
    checkOutput("t6_greset_pulse", 32'(sGrs), 1);
    checkOutput("t6_greset_one_cycle", 32'(sGrsAfter), 0);
    checkOutput("t6_greset_count", 32'(grsPulses - g0), 1);
    checkOutput("t6_flags_cleared", 32'({STPeligro, STAlerta, STGas}), 0);
    checkOutput("t6_fields_kept", 32'(STtemp), 'h0042);
    checkOutput("t6_sel_kept", 32'(FIELD_SEL), 1);

    applyStimulus(8'h5A);
    applyStimulus(8'h26);
    checkOutput("t6_busy_before_rst", 32'(BUSY), 1);
    DATO   = 8'h5A;
    flag   = 1'b1;
    RESETn = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t6_rst_sttemp", 32'(STtemp), 0);
    checkOutput("t6_rst_sel", 32'(FIELD_SEL), 0);
    checkOutput("t6_rst_busy", 32'(BUSY), 0);
    checkOutput("t6_rst_pulses", 32'({Greset, CMD_VALID, ERR}), 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("t6_held_flag_ignored", 32'(BUSY), 0);
    flag = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    applyStimulus(8'h5A);
    checkOutput("t6_toggle_accepted", 32'(BUSY), 1);
    applyStimulus(8'h76);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
